kernel: RTL and testbench



---
 rtl/kernel_pkg.sv | 20 ++
 rtl/kernel_popcount.sv | 29 ++
 rtl/kernel.sv | 81 ++++++++
 tb/tb_kernel.sv | 129 ++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// Shared constants and types for the binary 3x3 convolution kernel tile.
// Optional input registering is selected with the KERNEL_IN_REG_EN macro.
package kernel_pkg;

  localparam int N_TAPS = 9;
  localparam int SKIP_W = 4;
  localparam int PSUM_W = 5;

  typedef logic [N_TAPS-1:0]        act_t;
  typedef logic [N_TAPS-1:0]        wgt_t;
  typedef logic [SKIP_W-1:0]        skip_t;
  typedef logic signed [PSUM_W-1:0] psum_t;

  // Skip counts above N_TAPS mask every lane, exactly like N_TAPS itself.
  function automatic skip_t sat_skip(input skip_t skip);
    if (skip > skip_t'(N_TAPS)) return skip_t'(N_TAPS);
    return skip;
  endfunction

endpackage

// File: rtl/kernel_popcount.sv
// Masked 9-bit popcount built as a balanced adder tree (pairs, quads, octet, plus lane 8).
module kernel_popcount
  import kernel_pkg::*;
(
  input  logic [N_TAPS-1:0] i_bits,
  input  logic [N_TAPS-1:0] i_mask,
  output logic [SKIP_W-1:0] o_count
);

  logic [N_TAPS-1:0] w_m;
  logic [1:0]        w_s0, w_s1, w_s2, w_s3;
  logic [2:0]        w_t0, w_t1;
  logic [3:0]        w_u;

  assign w_m = i_bits & i_mask;

  assign w_s0 = {1'b0, w_m[0]} + {1'b0, w_m[1]};
  assign w_s1 = {1'b0, w_m[2]} + {1'b0, w_m[3]};
  assign w_s2 = {1'b0, w_m[4]} + {1'b0, w_m[5]};
  assign w_s3 = {1'b0, w_m[6]} + {1'b0, w_m[7]};

  assign w_t0 = {1'b0, w_s0} + {1'b0, w_s1};
  assign w_t1 = {1'b0, w_s2} + {1'b0, w_s3};

  assign w_u  = {1'b0, w_t0} + {1'b0, w_t1};

  assign o_count = w_u + {3'b000, w_m[8]};

endmodule

// File: rtl/kernel.sv
// Binary 3x3 convolution tile: XNOR, skip mask, +/-1 sum, registered 5-bit partial sum.
// Define KERNEL_IN_REG_EN to register the inputs first (latency 2 instead of 1).
module kernel
  import kernel_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [N_TAPS-1:0] activation_in,
  input  logic [N_TAPS-1:0] weight_in,
  input  logic [SKIP_W-1:0] skip_in,
  output logic [PSUM_W-1:0] psum_out
);

  act_t  w_act;
  wgt_t  w_wgt;
  skip_t w_skip;

`ifdef KERNEL_IN_REG_EN
  act_t  r_act;
  wgt_t  r_wgt;
  skip_t r_skip;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_act  <= '0;
      r_wgt  <= '0;
      r_skip <= '0;
    end else begin
      r_act  <= activation_in;
      r_wgt  <= weight_in;
      r_skip <= skip_in;
    end
  end

  assign w_act  = r_act;
  assign w_wgt  = r_wgt;
  assign w_skip = r_skip;
`else
  assign w_act  = activation_in;
  assign w_wgt  = weight_in;
  assign w_skip = skip_in;
`endif

  act_t  w_prod;
  act_t  w_mask;
  skip_t w_skip_sat;
  skip_t w_active;
  skip_t w_match;
  psum_t w_psum;

  assign w_prod     = ~(w_act ^ w_wgt);
  assign w_skip_sat = sat_skip(w_skip);
  assign w_active   = skip_t'(N_TAPS) - w_skip_sat;

  // Lanes are masked from bit 0 upward.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      w_mask[i] = (skip_t'(i) >= w_skip_sat);
    end
  end

  kernel_popcount u_popcount (
    .i_bits  (w_prod),
    .i_mask  (w_mask),
    .o_count (w_match)
  );

  // 2*M - A lies in -9..+9, so 5-bit modular arithmetic is exact.
  assign w_psum = psum_t'({w_match, 1'b0} - {1'b0, w_active});

  psum_t r_psum;

  always_ff @(posedge clk_in) begin
    if (reset_in) r_psum <= '0;
    else          r_psum <= w_psum;
  end

  assign psum_out = r_psum;

endmodule

// File: tb/tb_kernel.sv
// Directed and streaming bench for kernel; latency follows KERNEL_IN_REG_EN.
module tb_kernel;

`ifdef KERNEL_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk_in;
  logic       reset_in;
  logic [8:0] activation_in;
  logic [8:0] weight_in;
  logic [3:0] skip_in;
  logic [4:0] psum_out;

  int n_checks;
  int n_pass;
  logic [4:0] exp_q[$];

  kernel dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .activation_in (activation_in),
    .weight_in     (weight_in),
    .skip_in       (skip_in),
    .psum_out      (psum_out)
  );

  // Clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference: walk the lanes and add +1/-1/0 directly.
  function automatic logic [4:0] golden(input logic [8:0] a, input logic [8:0] w,
                                        input logic [3:0] s);
    int sum;
    int k;
    sum = 0;
    k = (s > 4'd9) ? 9 : int'(s);
    for (int i = 0; i < 9; i++) begin
      if (i >= k) sum += (a[i] == w[i]) ? 1 : -1;
    end
    return sum[4:0];
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b (%0d) expected %b (%0d)", tag, got, $signed(got),
                  exp, $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [8:0] a, input logic [8:0] w, input logic [3:0] s);
    activation_in = a;
    weight_in     = w;
    skip_in       = s;
  endtask

  // Hold a vector for LAT edges and compare against a hand-computed value.
  task automatic apply(input string tag, input logic [8:0] a, input logic [8:0] w,
                       input logic [3:0] s, input logic [4:0] exp);
    drive(a, w, s);
    repeat (LAT) tick();
    check(tag, psum_out, exp);
  endtask

  initial begin
    logic [8:0] a, w;
    logic [3:0] s;
    n_checks = 0;
    n_pass   = 0;

    // Reset with random inputs
    reset_in = 1'b1;
    drive(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
    tick();
    tick();
    check("reset", psum_out, 5'b00000);
    reset_in = 1'b0;

    apply("all_match",     9'h1FF, 9'h1FF, 4'd0, 5'b01001);
    apply("full_mismatch", 9'h000, 9'h1FF, 4'd0, 5'b10111);
    apply("match_0f0",     9'h0F0, 9'h0F0, 4'd0, 5'b01001);
    apply("mix_0f0_00f",   9'h0F0, 9'h00F, 4'd0, 5'b11001);
    apply("skip4_match",   9'h1FF, 9'h1FF, 4'd4, 5'b00101);
    apply("skip4_miss",    9'h000, 9'h1FF, 4'd4, 5'b11011);
    apply("skip8_match",   9'h0AA, 9'h0AA, 4'd8, 5'b00001);
    apply("skip8_miss",    9'h100, 9'h000, 4'd8, 5'b11111);
    apply("skip9",         9'h000, 9'h1FF, 4'd9, 5'b00000);
    apply("skip15",        9'h1FF, 9'h1FF, 4'd15, 5'b00000);
    apply("alt_skip0",     9'b101010101, 9'b111111111, 4'd0, 5'b00001);
    apply("alt_skip1",     9'b101010101, 9'b111111111, 4'd1, 5'b00000);

    // Back-to-back streaming, one vector per cycle
    exp_q.delete();
    for (int i = 0; i < 100 + LAT - 1; i++) begin
      a = 9'($urandom_range(0, 511));
      w = 9'($urandom_range(0, 511));
      s = 4'($urandom_range(0, 15));
      drive(a, w, s);
      if (i < 100) exp_q.push_back(golden(a, w, s));
      tick();
      if (i >= LAT - 1) begin
        if (exp_q.size() == 0) check("stream_underflow", psum_out, 5'bxxxxx);
        else check($sformatf("stream[%0d]", i - (LAT - 1)), psum_out, exp_q.pop_front());
      end
    end

    // Mid-stream reset discards in-flight results
    drive(9'h1FF, 9'h1FF, 4'd0);
    tick();
    reset_in = 1'b1;
    drive(9'h0F0, 9'h0F0, 4'd2);
    tick();
    check("mid_reset", psum_out, 5'b00000);
    reset_in = 1'b0;
    apply("after_reset", 9'h000, 9'h1FF, 4'd3, 5'b11010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
